// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like slave: transfer size encodings and
// request FIFO entry layout widths.
package sram_like_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int CD_W   = 4;

  // Entry payload is {wr, wstrb, word index, wdata}; the index width is added
  // by the user since it depends on the backing-store size.
  localparam int ENTRY_FIXED_W = 1 + STRB_W + DATA_W;

endpackage

// File: rtl/sram_req_fifo.sv
// In-order request FIFO with a per-entry latency countdown; the head is
// reported ready once its countdown has reached zero.
module sram_req_fifo
  import sram_like_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = 2,
  parameter int PW    = ENTRY_FIXED_W + 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [PW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] head_data,
  output logic          head_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CD_W-1:0] CD_INIT = CD_W'(LAT - 1);

  logic [PW-1:0]   data_q [DEPTH];
  logic [CD_W-1:0] cd_q   [DEPTH];
  logic [PTR_W:0]  wptr;
  logic [PTR_W:0]  rptr;
  logic [PTR_W:0]  count;
  logic [PTR_W-1:0] wslot;
  logic [PTR_W-1:0] rslot;
  logic [PTR_W-1:0] slot_off;
  logic [DEPTH-1:0] valid;
  logic            do_push;
  logic            do_pop;

  assign wslot      = wptr[PTR_W-1:0];
  assign rslot      = rptr[PTR_W-1:0];
  assign count      = wptr - rptr;
  assign empty      = (wptr == rptr);
  assign full       = (wptr[PTR_W] != rptr[PTR_W]) && (wslot == rslot);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign head_data  = data_q[rslot];
  assign head_ready = !empty && (cd_q[rslot] == '0);

  // A slot holds a live entry when its distance from the read slot is
  // below the current occupancy.
  always_comb begin
    valid    = '0;
    slot_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PTR_W'(i) - rslot;
      valid[i] = ({1'b0, slot_off} < count);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        cd_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        wptr <= wptr + (PTR_W + 1)'(1);
      end
      if (do_pop) begin
        rptr <= rptr + (PTR_W + 1)'(1);
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (do_push && (wslot == PTR_W'(i))) begin
          cd_q[i] <= CD_INIT;
        end else if (valid[i] && (cd_q[i] != '0)) begin
          cd_q[i] <= cd_q[i] - CD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      data_q[wslot] <= push_data;
    end
  end

endmodule

// File: rtl/sram_like_slave.sv
// SRAM-like slave: fixed-latency, in-order responder over a word array.
// Optional random accept stalls are enabled by defining SRAM_SLAVE_STALL_EN.
module sram_like_slave
  import sram_like_pkg::*;
#(
  parameter int AW    = 12,
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PW = ENTRY_FIXED_W + AW;

  logic [DATA_W-1:0] mem [2**AW];

  logic              full;
  logic              empty;
  logic              head_ready;
  logic              push;
  logic [PW-1:0]     push_data;
  logic [PW-1:0]     head_data;
  logic              head_wr;
  logic [STRB_W-1:0] head_strb;
  logic [AW-1:0]     head_idx;
  logic [DATA_W-1:0] head_wdata;

  // Size is informational; lane handling is done by the initiator via wstrb.
  size_e unused_size;
  logic  unused_addr;
  logic  unused_empty;
  assign unused_size  = size_e'(size);
  assign unused_addr  = ^{addr[31:AW+2], addr[1:0]};
  assign unused_empty = empty;

`ifdef SRAM_SLAVE_STALL_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
  end

  assign addr_ok = !reset && !full && lfsr[0];
`else
  assign addr_ok = !reset && !full;
`endif

  assign push      = req && addr_ok;
  assign push_data = {wr, wstrb, addr[AW+1:2], wdata};
  assign {head_wr, head_strb, head_idx, head_wdata} = head_data;

  sram_req_fifo #(
    .DEPTH (DEPTH),
    .LAT   (LAT),
    .PW    (PW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_data),
    .pop        (data_ok),
    .full       (full),
    .empty      (empty),
    .head_data  (head_data),
    .head_ready (head_ready)
  );

  assign data_ok = head_ready && !reset;
  assign rdata   = (data_ok && !head_wr) ? mem[head_idx] : '0;

  // Writes commit at the completion edge, so later reads see them in order.
  always_ff @(posedge clk) begin
    if (data_ok && head_wr) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (head_strb[b]) begin
          mem[head_idx][8*b +: 8] <= head_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_like_slave.sv
// Directed and model-checked bench for sram_like_slave; u_dut2 uses LAT=2,
// u_dut4 uses LAT=4 for the full-FIFO and mid-flight reset scenarios.
module tb_sram_like_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req2 = 1'b0;
  logic        req4 = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        addr_ok2, data_ok2, addr_ok4, data_ok4;
  logic [31:0] rdata2, rdata4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_like_slave #(.AW(12), .DEPTH(4), .LAT(2)) u_dut2 (
    .clk(clk), .reset(reset), .req(req2), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok2), .data_ok(data_ok2), .rdata(rdata2)
  );

  sram_like_slave #(.AW(12), .DEPTH(4), .LAT(4)) u_dut4 (
    .clk(clk), .reset(reset), .req(req4), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok4), .data_ok(data_ok4), .rdata(rdata4)
  );

  task automatic drive(input logic r2, input logic r4, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    req2  = r2;
    req4  = r4;
    wr    = w;
    addr  = a;
    wdata = d;
    wstrb = s;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({addr_ok2, data_ok2, addr_ok4, data_ok4} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_hs: got %b expected 0000", {addr_ok2, data_ok2, addr_ok4, data_ok4});
    end
    n_cmp++;
    if ({rdata2, rdata4} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h expected 0", {rdata2, rdata4});
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({data_ok2, data_ok4} !== 2'b00) begin
      n_err++;
      $display("FAIL post_reset_dok: got %b expected 00", {data_ok2, data_ok4});
    end
`ifndef SRAM_SLAVE_STALL_EN
    n_cmp++;
    if ({addr_ok2, addr_ok4} !== 2'b11) begin
      n_err++;
      $display("FAIL post_reset_aok: got %b expected 11", {addr_ok2, addr_ok4});
    end
`endif
    next_cycle();
  endtask

  task automatic test_single_write();
    drive(1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    n_cmp++;
    if ({addr_ok2, data_ok2} !== 2'b10) begin
      n_err++;
      $display("FAIL sw_accept: got %b expected 10", {addr_ok2, data_ok2});
    end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({data_ok2, rdata2} !== {(k == 2), 32'h0}) begin
        n_err++;
        $display("FAIL sw_t%0d: got dok=%b rdata=%h expected dok=%b rdata=0", k, data_ok2, rdata2, (k == 2));
      end
      next_cycle();
    end
  endtask

  task automatic test_read();
    drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    n_cmp++;
    if (addr_ok2 !== 1'b1) begin
      n_err++;
      $display("FAIL rd_accept: got %b expected 1", addr_ok2);
    end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({data_ok2, rdata2} !== ((k == 2) ? {1'b1, 32'hDEADBEEF} : 33'h0)) begin
        n_err++;
        $display("FAIL rd_t%0d: got dok=%b rdata=%h", k, data_ok2, rdata2);
      end
      next_cycle();
    end
  endtask

  task automatic test_partial_write();
    logic [32:0] exp;
    drive(1'b1, 1'b0, 1'b1, 32'h10, 32'h0000_5500, 4'b0010);
    @(negedge clk);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    n_cmp++;
    if ({addr_ok2, data_ok2} !== 2'b10) begin
      n_err++;
      $display("FAIL pw_rd_accept: got %b expected 10", {addr_ok2, data_ok2});
    end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 2; k <= 4; k++) begin
      case (k)
        2:       exp = {1'b1, 32'h0};
        3:       exp = {1'b1, 32'hDEAD55EF};
        default: exp = 33'h0;
      endcase
      @(negedge clk);
      n_cmp++;
      if ({data_ok2, rdata2} !== exp) begin
        n_err++;
        $display("FAIL pw_t%0d: got %h expected %h", k, {data_ok2, rdata2}, exp);
      end
      next_cycle();
    end
  endtask

  // LAT=4, DEPTH=4: four accepts fill the FIFO, one stall cycle, then the
  // first completion frees a slot. Writes precede reads to expose ordering.
  task automatic test_full_stall();
    logic [10:0] aok_exp;
    logic [10:0] dok_exp;
    logic [31:0] rd_exp;
    aok_exp = 11'b111_1110_1111;
    dok_exp = 11'b010_1111_0000;
    for (int c = 0; c <= 10; c++) begin
      case (c)
        0:       drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h1111_1111, 4'hF);
        1:       drive(1'b0, 1'b1, 1'b1, 32'h24, 32'h2222_2222, 4'hF);
        2:       drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        3, 4, 5: drive(1'b0, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0);
        default: drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      endcase
      case (c)
        6:       rd_exp = 32'h1111_1111;
        7, 9:    rd_exp = 32'h2222_2222;
        default: rd_exp = 32'h0;
      endcase
      @(negedge clk);
      n_cmp++;
      if (addr_ok4 !== aok_exp[c]) begin
        n_err++;
        $display("FAIL fs_aok_c%0d: got %b expected %b", c, addr_ok4, aok_exp[c]);
      end
      n_cmp++;
      if ({data_ok4, rdata4} !== {dok_exp[c], rd_exp}) begin
        n_err++;
        $display("FAIL fs_dok_c%0d: got dok=%b rdata=%h expected dok=%b rdata=%h",
                 c, data_ok4, rdata4, dok_exp[c], rd_exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
      @(negedge clk);
      n_cmp++;
      if ({addr_ok4, data_ok4} !== 2'b10) begin
        n_err++;
        $display("FAIL rm_accept_c%0d: got %b expected 10", c, {addr_ok4, data_ok4});
      end
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({addr_ok4, data_ok4, rdata4} !== 34'h0) begin
      n_err++;
      $display("FAIL rm_immediate: got aok=%b dok=%b rdata=%h expected 0", addr_ok4, data_ok4, rdata4);
    end
    repeat (2) next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({addr_ok4, data_ok4} !== 2'b10) begin
        n_err++;
        $display("FAIL rm_after_c%0d: got %b expected 10", c, {addr_ok4, data_ok4});
      end
      next_cycle();
    end
    drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    @(negedge clk);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({data_ok4, rdata4} !== ((k == 4) ? {1'b1, 32'h1111_1111} : 33'h0)) begin
        n_err++;
        $display("FAIL rm_new_t%0d: got dok=%b rdata=%h", k, data_ok4, rdata4);
      end
      next_cycle();
    end
  endtask

  typedef struct packed {
    logic [31:0] t;
    logic        w;
    logic [3:0]  strb;
    logic [3:0]  idx;
    logic [31:0] d;
  } txn_t;

  // Reference model for LAT=2, DEPTH=4: completion at accept+2, in order.
  task automatic test_random();
    txn_t        exp_q[$];
    txn_t        pend;
    txn_t        head;
    logic [31:0] mm [16];
    logic        exp_dok;
    logic [31:0] exp_rd;
    logic        acc;
    int          n_acc;
    int          cyc;
    n_acc = 0;
    cyc   = 0;
    pend  = '{t: 32'h0, w: 1'b1, strb: 4'hF, idx: 4'h0, d: $urandom};
    while (!(n_acc == 1000 && exp_q.size() == 0) && cyc < 20000) begin
      if (n_acc < 1000) begin
        req2  = ($urandom_range(0, 3) != 0);
        wr    = pend.w;
        wstrb = pend.strb;
        addr  = {26'h0, pend.idx, 2'(2'($urandom_range(0, 3)))};
        wdata = pend.d;
        size  = 2'($urandom_range(0, 2));
      end else begin
        req2 = 1'b0;
      end
      @(negedge clk);
`ifdef SRAM_SLAVE_STALL_EN
      n_cmp++;
      if (addr_ok2 && exp_q.size() == 4) begin
        n_err++;
        $display("FAIL rnd_aok_full cyc%0d: got 1 expected 0", cyc);
      end
`else
      n_cmp++;
      if (addr_ok2 !== (exp_q.size() != 4)) begin
        n_err++;
        $display("FAIL rnd_aok cyc%0d: got %b expected %b", cyc, addr_ok2, (exp_q.size() != 4));
      end
`endif
      exp_dok = 1'b0;
      exp_rd  = 32'h0;
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        if (cyc >= int'(head.t) + 2) begin
          exp_dok = 1'b1;
          exp_rd  = head.w ? 32'h0 : mm[head.idx];
        end
      end
      n_cmp++;
      if ({data_ok2, rdata2} !== {exp_dok, exp_rd}) begin
        n_err++;
        $display("FAIL rnd_cpl cyc%0d: got dok=%b rdata=%h expected dok=%b rdata=%h",
                 cyc, data_ok2, rdata2, exp_dok, exp_rd);
      end
      acc = req2 && addr_ok2;
      @(posedge clk);
      if (exp_dok) begin
        head = exp_q.pop_front();
        if (head.w) begin
          for (int b = 0; b < 4; b++) begin
            if (head.strb[b]) mm[head.idx][8*b +: 8] = head.d[8*b +: 8];
          end
        end
      end
      if (acc) begin
        pend.t = 32'(cyc);
        exp_q.push_back(pend);
        n_acc++;
        if (n_acc < 16) begin
          pend = '{t: 32'h0, w: 1'b1, strb: 4'hF, idx: 4'(n_acc), d: $urandom};
        end else begin
          pend = '{t: 32'h0, w: 1'($urandom_range(0, 1)), strb: 4'($urandom_range(0, 15)),
                   idx: 4'($urandom_range(0, 15)), d: $urandom};
        end
      end
      cyc++;
      #1;
    end
    n_cmp++;
    if (n_acc != 1000 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rnd_timeout: got %0d accepted %0d pending expected 1000 accepted 0 pending",
               n_acc, exp_q.size());
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    test_reset();
`ifndef SRAM_SLAVE_STALL_EN
    test_single_write();
    test_read();
    test_partial_write();
    test_full_stall();
    test_reset_mid();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_like_slave.md
SRAM_LIKE_SLAVE -- requirements
Module: sram_like_slave

Interface
REQ-001 SHALL have parameter AW, default 12: backing-store word-address width, giving 2^AW 32-bit words.
REQ-002 SHALL have parameter DEPTH, default 4, power of two: maximum outstanding accepted requests.
REQ-003 SHALL have parameter LAT, default 2, legal 1..15: cycles from accept to data_ok.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port req, input, 1: the initiator has a request.
REQ-007 SHALL have port wr, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port size, input, 2: 0 = byte, 1 = half, 2 = word; informational only.
REQ-009 SHALL have port wstrb, input, 4: byte-lane write enables.
REQ-010 SHALL have port addr, input, 32: byte address; word index addr[AW+1:2].
REQ-011 SHALL have port wdata, input, 32: write data.
REQ-012 SHALL have port addr_ok, output, 1: request accepted this cycle when req is also high.
REQ-013 SHALL have port data_ok, output, 1: the oldest outstanding request completes this cycle.
REQ-014 SHALL have port rdata, output, 32: read data, qualified by data_ok.

Function
REQ-015 SHALL accept a request exactly in a cycle where req and addr_ok are both 1, pushing {wr, wstrb, word index, wdata, countdown = LAT-1} into the FIFO at that edge.
REQ-016 SHALL drive addr_ok = !full, with no same-cycle pop bypass; a full FIFO stalls even while data_ok is high.
REQ-017 SHALL decrement every valid entry's countdown each cycle, saturating at 0.
REQ-018 SHALL assert data_ok when the FIFO is non-empty and the head countdown is 0, and pop the head at that edge; a request accepted in cycle t completes no earlier than cycle t+LAT.
REQ-019 SHALL complete requests strictly in acceptance order, at most one completion per cycle; back-to-back accepts give back-to-back data_ok.
REQ-020 SHALL, on a read completion, drive rdata = mem[head index] combinationally during the data_ok cycle; rdata SHALL be 0 whenever there is no read completion.
REQ-021 SHALL, on a write completion, update the bytes of mem[head index] selected by wstrb at the data_ok edge; wstrb = 0 writes nothing but still completes.
REQ-022 SHALL give a read completing after an earlier write to the same word the post-write data, because commit is in order.
REQ-023 SHALL allow a push and a pop in the same cycle when not full; occupancy is unchanged in that cycle.
REQ-024 SHALL let FIFO pointers wrap modulo DEPTH, with full and empty distinguished by an extra pointer bit.
REQ-025 SHALL ignore size, since lane selection is the initiator's job through wstrb and its own rdata extraction.

Reset
REQ-026 SHALL, while reset is high, hold addr_ok = 0, data_ok = 0, rdata = 0, FIFO empty and all countdowns 0.
REQ-027 SHALL discard all outstanding requests if reset asserts mid-operation; no late data_ok may follow reset.
REQ-028 SHALL not reset the backing-store contents.

Configuration
REQ-029 SHALL, when SRAM_SLAVE_STALL_EN is defined, gate addr_ok with a 16-bit LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1, stepping every cycle), so addr_ok = !full & lfsr[0].
REQ-030 SHALL, when SRAM_SLAVE_STALL_EN is undefined, contain no LFSR, and addr_ok = !full.

Structure
REQ-031 SHALL take the size encodings (byte/half/word) and the FIFO entry layout widths from shared package sram_like_pkg.
REQ-032 SHALL contain one sub-module, sram_req_fifo: parameterised DEPTH entries with per-entry countdown, push, pop, full, empty and a head view; the array and the responder logic sit in sram_like_slave.

Verification
REQ-033 Bench SHALL check: single write 0x0000_0010 = 0xDEADBEEF, wstrb = 4'hF, accepted cycle t -> data_ok in cycle t+2 only.
REQ-034 Bench SHALL check: read of 0x10 after REQ-033 -> data_ok two cycles after accept with rdata = 0xDEADBEEF.
REQ-035 Bench SHALL check: write 0x10 wdata = 0x0000_5500 wstrb = 4'b0010, then read 0x10 issued the next cycle -> rdata = 0xDEAD55EF, two consecutive data_ok cycles.
REQ-036 Bench SHALL check: req held high for 6 cycles with LAT = 4, DEPTH = 4, stall macro off -> addr_ok high for 4 cycles, low for 1, then high again as the first pop frees a slot; completions stay in order.
REQ-037 Bench SHALL check: reset asserted with 3 requests outstanding -> data_ok and addr_ok go low immediately, with no data_ok after reset release until a new accept.
REQ-038 Bench SHALL check: with SRAM_SLAVE_STALL_EN defined, 1000 random requests -> every completion matches a reference model and addr_ok is never high while full.
